// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus for program_loader.
// The loader side uses the slave modport; the stream source and observers use master.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned WORD_W = 12;
  localparam int unsigned CNT_W  = 9;

  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              pmem_le;
  logic              pmem_we;
  logic [ADDR_W-1:0] pmem_addr;
  logic [WORD_W-1:0] pmem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  word_count;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, pmem_le, pmem_we, pmem_addr, pmem_wdata,
           busy, done, error, word_count
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, pmem_le, pmem_we, pmem_addr, pmem_wdata,
           busy, done, error, word_count
  );
endinterface

// File: rtl/program_loader.sv
// Program-memory writer: assembles 12-bit words from a COUNT/HI/LO byte stream.
// Optional trailing checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);

  localparam int unsigned WORD_W = 12;
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_DONE,
    ST_ERROR,
    ST_CSUM
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
  logic [WORD_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              pmem_we_q, pmem_we_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  assign accept = bus.in_valid && in_ready_q;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      nibble_q     <= '0;
      word_count_q <= '0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      pmem_we_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      nibble_q     <= nibble_d;
      word_count_q <= word_count_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      pmem_we_q    <= pmem_we_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // Next-state and datapath updates; status outputs are decoded from the next state
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    nibble_d     = nibble_q;
    word_count_d = word_count_q;
    pmem_addr_d  = pmem_addr_q;
    pmem_wdata_d = pmem_wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    if (accept) sum_d = sum_q + bus.in_data;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.start) begin
          state_d      = ST_COUNT;
          ptr_d        = '0;
          word_count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end
      ST_COUNT: begin
        if (accept) begin
          // A count byte of zero encodes the full 256-word image
          remaining_d = (bus.in_data == 8'd0) ? CNT_W'(256) : CNT_W'(bus.in_data);
          state_d     = ST_HI;
        end
      end
      ST_HI: begin
        if (accept) begin
          if (bus.in_data[7:4] != 4'd0) begin
            state_d = ST_ERROR;
          end else begin
            nibble_d = bus.in_data[3:0];
            state_d  = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (accept) begin
          pmem_addr_d  = ptr_q;
          pmem_wdata_d = {nibble_q, bus.in_data};
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ptr_d        = ptr_q + ADDR_W'(1);
        word_count_d = word_count_q + CNT_W'(1);
        remaining_d  = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d = ((sum_q + bus.in_data) == 8'd0) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_COUNT) || (state_d == ST_HI) ||
                 (state_d == ST_LO)    || (state_d == ST_CSUM);
    busy_d     = in_ready_d || (state_d == ST_WRITE);
    pmem_we_d  = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.pmem_le    = busy_q;
  assign bus.pmem_we    = pmem_we_q;
  assign bus.pmem_addr  = pmem_addr_q;
  assign bus.pmem_wdata = pmem_wdata_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a stream-level reference model.
// Define PROGRAM_LOADER_CHECKSUM_EN to exercise the checksum build.
module tb_program_loader;

  localparam int unsigned ADDR_W = 8;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();
  program_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  bytes_t      stim;
  logic [19:0] wr_log[$];
  logic [19:0] saved_log[$];
  logic [19:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_wc;
  int          exp_used;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe as {addr, data}
  always @(posedge clk) begin
    if (bus.pmem_we) wr_log.push_back({bus.pmem_addr, bus.pmem_wdata});
  end

  // Reference: interpret the byte stream directly
  task automatic model(input bytes_t s);
    int n;
    int i;
    logic [7:0] hi;
    logic [7:0] lo;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_wc   = 0;
    n = (s[0] == 8'd0) ? 256 : int'(s[0]);
    i = 1;
    for (int w = 0; w < n; w++) begin
      hi = s[i]; i++;
      if (hi[7:4] != 4'd0) begin
        exp_err  = 1;
        exp_used = i;
        return;
      end
      lo = s[i]; i++;
      exp_q.push_back({8'(w), hi[3:0], lo});
      exp_wc++;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] sum;
      sum = 8'd0;
      for (int k = 0; k <= i; k++) sum = sum + s[k];
      i++;
      exp_err  = (sum != 8'd0);
      exp_done = !exp_err;
    end
`else
    exp_done = 1;
`endif
    exp_used = i;
  endtask

  task automatic finish_stim();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'd0;
    foreach (stim[k]) sum = sum + stim[k];
    stim.push_back(8'd0 - sum);
`endif
  endtask

  task automatic add_word(input bit bad);
    logic [7:0] hi;
    hi = 8'($urandom_range(0, 15));
    if (bad) hi = hi | 8'($urandom_range(1, 15) << 4);
    stim.push_back(hi);
    stim.push_back(8'($urandom));
  endtask

  task automatic drive_bytes(input int cnt, input bit gaps, input int start_at);
    for (int k = 0; k < cnt; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          bus.start    = 1'b0;
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = stim[k];
      bus.start    = (k == start_at);
      begin
        int t;
        t = 0;
        while (!bus.in_ready && t < 20) begin
          @(negedge clk);
          bus.start = 1'b0;
          t++;
        end
        if (!bus.in_ready) check("ready_timeout", 32'(k), 32'hFFFF_FFFF);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic run_session(input string name, input bit gaps, input int start_at);
    int t;
    model(stim);
    wr_log.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_busy_on_start"}, {bus.busy, bus.pmem_le, bus.done, bus.error}, 4'b1100);
    check({name, "_wc_cleared"}, 32'(bus.word_count), 0);
    drive_bytes(exp_used, gaps, start_at);
    t = 0;
    while (!(bus.done || bus.error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, 32'(bus.done), 32'(exp_done));
    check({name, "_error"}, 32'(bus.error), 32'(exp_err));
    check({name, "_word_count"}, 32'(bus.word_count), 32'(exp_wc));
    check({name, "_idle_outputs"}, {bus.busy, bus.pmem_le, bus.in_ready, bus.pmem_we}, 4'b0000);
    check({name, "_write_count"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
      check($sformatf("%s_write%0d", name, k), 32'(wr_log[k]), 32'(exp_q[k]));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_flags"}, {bus.in_ready, bus.pmem_le, bus.pmem_we, bus.busy, bus.done, bus.error}, 6'd0);
    check({name, "_addr"}, 32'(bus.pmem_addr), 0);
    check({name, "_wdata"}, 32'(bus.pmem_wdata), 0);
    check({name, "_wc"}, 32'(bus.word_count), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Two-word stream, valid held
    stim = '{8'h02, 8'h0A, 8'h12, 8'h01, 8'hFF};
    finish_stim();
    run_session("basic", 0, -1);
    if (wr_log.size() == 2) begin
      check("basic_addr0", 32'(wr_log[0]), 32'({8'h00, 12'hA12}));
      check("basic_addr1", 32'(wr_log[1]), 32'({8'h01, 12'h1FF}));
    end else begin
      check("basic_log_len", 32'(wr_log.size()), 2);
    end

    // Nonzero upper nibble in HI aborts
    stim = '{8'h01, 8'h35};
    finish_stim();
    run_session("bad_hi", 0, -1);

    // Full 256-word image
    stim = '{8'h00};
    for (int w = 0; w < 256; w++) add_word(0);
    finish_stim();
    run_session("full256", 0, -1);
    if (wr_log.size() == 256) check("full256_last_addr", 32'(wr_log[255][19:12]), 32'd255);

    // Gapped stream with a mid-session start matches the back-to-back result
    stim = '{8'h03};
    for (int w = 0; w < 3; w++) add_word(0);
    finish_stim();
    run_session("b2b", 0, -1);
    saved_log = wr_log;
    run_session("gapped", 1, 3);
    check("gapped_len_vs_b2b", 32'(wr_log.size()), 32'(saved_log.size()));
    for (int k = 0; k < saved_log.size() && k < wr_log.size(); k++)
      check($sformatf("gapped_vs_b2b%0d", k), 32'(wr_log[k]), 32'(saved_log[k]));

    // Reset between HI and LO of word 1
    stim = '{8'h02, 8'h0A, 8'h12, 8'h01};
    wr_log.delete();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    drive_bytes(4, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_reset_writes", 32'(wr_log.size()), 1);
    stim = '{8'h02, 8'h0A, 8'h12, 8'h01, 8'hFF};
    finish_stim();
    run_session("after_reset", 0, -1);

    // Randomized sessions, some with a bad HI byte
    for (int r = 0; r < 20; r++) begin
      int n;
      int bad_at;
      n = $urandom_range(1, 6);
      bad_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      stim = '{8'(n)};
      for (int w = 0; w < n; w++) add_word(w == bad_at);
      finish_stim();
      run_session($sformatf("rand%0d", r), 1, int'($urandom_range(1, 4)));
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stim = '{8'h01, 8'h0B, 8'hCD, 8'h27};
    run_session("csum_good", 0, -1);
    check("csum_good_done", 32'(bus.done), 1);
    stim = '{8'h01, 8'h0B, 8'hCD, 8'h28};
    run_session("csum_bad", 0, -1);
    check("csum_bad_error", 32'(bus.error), 1);
    if (wr_log.size() == 1) check("csum_bad_written", 32'(wr_log[0]), 32'({8'h00, 12'hBCD}));
    else check("csum_bad_log_len", 32'(wr_log.size()), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
